// File: rtl/guess_input_ctrl.sv
// Player input front end for Bulls & Cows: synchronises and debounces the confirm button,
// snapshots the switches as four BCD digits and reports either an accepted guess or a rejection cause.
module guess_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] sw,
    input  logic        confirm,
    input  logic        accept,
    output logic [15:0] guess,
    output logic        guess_valid,
    output logic        guess_error,
    output logic [1:0]  err_code,
    output logic        busy,
    output logic        btn_level
);
    localparam int unsigned SW_W  = 16;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_DEC  = 2'd1;
    localparam logic [1:0] ERR_DUP  = 2'd2;

    typedef enum logic [1:0] {
        WAIT_PRESS,
        CAPTURE,
        CHECK,
        WAIT_RELEASE
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0]           confirm_sync;
    logic [SYNC_STAGES-1:0][SW_W-1:0] sw_sync;
    logic                             confirm_s;
    logic [SW_W-1:0]                  sw_s;

    logic [CNT_W-1:0] db_cnt;
    logic             btn_prev;
    logic             press_evt;

    logic [SW_W-1:0] snap;
    logic            dec_err;
    logic            dup_err;
    logic            dec_chk;
    logic            dup_chk;

    logic            snap_load;
    logic            valid_next;
    logic            error_next;
    logic [1:0]      code_next;

    // Input synchronisers; bit/stage 0 is nearest the pin
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            confirm_sync <= '0;
            sw_sync      <= '0;
        end else begin
            confirm_sync <= {confirm_sync[SYNC_STAGES-2:0], confirm};
            sw_sync      <= {sw_sync[SYNC_STAGES-2:0], sw};
        end
    end

    assign confirm_s = confirm_sync[SYNC_STAGES-1];
    assign sw_s      = sw_sync[SYNC_STAGES-1];

    // Level changes only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_cnt    <= '0;
            btn_level <= 1'b0;
            btn_prev  <= 1'b0;
        end else begin
            btn_prev <= btn_level;
            if (confirm_s == btn_level) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_level <= ~btn_level;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    assign press_evt = btn_level & ~btn_prev;

    // Snapshot validation: any non-decimal nibble, any equal pair among the four digits
    always_comb begin
        dec_chk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (snap[4*i +: 4] > 4'd9) dec_chk = 1'b1;
        end
        dup_chk = (snap[3:0]   == snap[7:4])   | (snap[3:0]  == snap[11:8])  |
                  (snap[3:0]   == snap[15:12]) | (snap[7:4]  == snap[11:8])  |
                  (snap[7:4]   == snap[15:12]) | (snap[11:8] == snap[15:12]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= WAIT_PRESS;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        snap_load  = 1'b0;
        valid_next = 1'b0;
        error_next = 1'b0;
        code_next  = ERR_NONE;
        case (state)
            WAIT_PRESS: begin
                if (press_evt && accept) begin
                    snap_load  = 1'b1;
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                state_next = CHECK;
            end
            CHECK: begin
                if (dec_err) begin
                    error_next = 1'b1;
                    code_next  = ERR_DEC;
                end else if (dup_err) begin
                    error_next = 1'b1;
                    code_next  = ERR_DUP;
                end else begin
                    valid_next = 1'b1;
                end
                state_next = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (!btn_level) state_next = WAIT_PRESS;
            end
            default: begin
                state_next = WAIT_PRESS;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snap        <= '0;
            dec_err     <= 1'b0;
            dup_err     <= 1'b0;
            guess       <= '0;
            guess_valid <= 1'b0;
            guess_error <= 1'b0;
            err_code    <= ERR_NONE;
            busy        <= 1'b0;
        end else begin
            if (snap_load) snap <= sw_s;
            if (state == CAPTURE) begin
                dec_err <= dec_chk;
                dup_err <= dup_chk;
            end
            if (valid_next) guess <= snap;
            guess_valid <= valid_next;
            guess_error <= error_next;
            err_code    <= code_next;
            busy        <= (state_next != WAIT_PRESS);
        end
    end

endmodule

// File: tb/tb_guess_input_ctrl.sv
// Self-checking bench for guess_input_ctrl: directed scenarios plus random presses,
// compared cycle by cycle against a behavioural model of the button/guess rules.
module tb_guess_input_ctrl;
    localparam int unsigned DB = 4;
    localparam int unsigned SS = 2;

    logic        clock;
    logic        reset;
    logic [15:0] sw;
    logic        confirm;
    logic        accept;
    logic [15:0] guess;
    logic        guess_valid;
    logic        guess_error;
    logic [1:0]  err_code;
    logic        busy;
    logic        btn_level;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_error  = 0;
    int n_rise   = 0;
    logic       obs_prev  = 1'b0;
    logic [1:0] last_code = 2'd0;

    guess_input_ctrl #(.DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SS)) dut (
        .clock       (clock),
        .reset       (reset),
        .sw          (sw),
        .confirm     (confirm),
        .accept      (accept),
        .guess       (guess),
        .guess_valid (guess_valid),
        .guess_error (guess_error),
        .err_code    (err_code),
        .busy        (busy),
        .btn_level   (btn_level)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural model: delayed inputs, "last DB samples all disagree" debounce,
    // and a press -> result-three-cycles-later -> wait-for-release sequence.
    logic        m_conf_q[$];
    logic [15:0] m_sw_q[$];
    logic        m_hist[$];
    logic        m_level, m_prev, m_wait, m_gv, m_ge, m_busy;
    int          m_delay;
    logic [15:0] m_snap, m_guess;
    logic [1:0]  m_code;

    function automatic logic [1:0] classify(input logic [15:0] v);
        bit seen [16];
        for (int i = 0; i < 16; i++) seen[i] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) return 2'd1;
        end
        for (int i = 0; i < 4; i++) begin
            if (seen[v[4*i +: 4]]) return 2'd2;
            seen[v[4*i +: 4]] = 1'b1;
        end
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_conf_q = {};
        m_sw_q   = {};
        m_hist   = {};
        for (int i = 0; i < int'(SS); i++) begin
            m_conf_q.push_back(1'b0);
            m_sw_q.push_back(16'h0);
        end
        for (int i = 0; i < int'(DB); i++) m_hist.push_back(1'b0);
        m_level = 1'b0; m_prev = 1'b0; m_wait = 1'b0; m_delay = 0;
        m_gv = 1'b0; m_ge = 1'b0; m_code = 2'd0; m_busy = 1'b0;
        m_snap = 16'h0; m_guess = 16'h0;
    endtask

    always @(posedge clock or posedge reset) begin
        logic        c_s;
        logic [15:0] s_s;
        logic        press;
        logic        all_diff;
        if (reset) begin
            model_reset();
        end else begin
            c_s = m_conf_q.pop_front();
            m_conf_q.push_back(confirm);
            s_s = m_sw_q.pop_front();
            m_sw_q.push_back(sw);
            press = m_level && !m_prev;
            m_gv = 1'b0; m_ge = 1'b0; m_code = 2'd0;
            if (m_wait) begin
                if (!m_level) m_wait = 1'b0;
            end else if (m_delay > 0) begin
                m_delay = m_delay - 1;
                if (m_delay == 0) begin
                    m_code = classify(m_snap);
                    if (m_code == 2'd0) begin
                        m_gv    = 1'b1;
                        m_guess = m_snap;
                    end else begin
                        m_ge = 1'b1;
                    end
                    m_wait = 1'b1;
                end
            end else if (press && accept) begin
                m_snap  = s_s;
                m_delay = 2;
            end
            m_busy = m_wait || (m_delay > 0);
            m_prev = m_level;
            void'(m_hist.pop_front());
            m_hist.push_back(c_s);
            all_diff = 1'b1;
            foreach (m_hist[i]) if (m_hist[i] == m_level) all_diff = 1'b0;
            if (all_diff) m_level = ~m_level;
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sample();
        check("btn_level",   16'(btn_level),   16'(m_level));
        check("guess_valid", 16'(guess_valid), 16'(m_gv));
        check("guess_error", 16'(guess_error), 16'(m_ge));
        check("err_code",    16'(err_code),    16'(m_code));
        check("guess",       guess,            m_guess);
        check("busy",        16'(busy),        16'(m_busy));
        if (guess_valid) n_valid++;
        if (guess_error) begin
            n_error++;
            last_code = err_code;
        end
        if (btn_level && !obs_prev) n_rise++;
        obs_prev = btn_level;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clock);
            sample();
        end
    endtask

    task automatic press(input int hold, input int rel);
        confirm = 1'b1;
        cyc(hold);
        confirm = 1'b0;
        cyc(rel);
    endtask

    function automatic logic [15:0] rand_distinct();
        logic [15:0] v = 16'h0;
        bit used [10];
        int d;
        for (int i = 0; i < 10; i++) used[i] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do d = int'($urandom_range(0, 9)); while (used[d]);
            used[d] = 1'b1;
            v[4*i +: 4] = 4'(d);
        end
        return v;
    endfunction

    initial begin
        int v0, e0, r0, budget, nb, hold;
        reset = 1'b0; sw = 16'h0; confirm = 1'b0; accept = 1'b0;
        #2 reset = 1'b1;
        cyc(3);
        check("rst_guess", guess, 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        reset = 1'b0;
        cyc(3);

        // Valid guess
        sw = 16'h1234; accept = 1'b1;
        cyc(3);
        v0 = n_valid; e0 = n_error;
        press(20, 15);
        check("valid_count", 16'(n_valid - v0), 16'd1);
        check("valid_noerr", 16'(n_error - e0), 16'd0);
        check("valid_guess", guess, 16'h1234);
        check("valid_busy_low", 16'(busy), 16'd0);

        // Repeated digit
        sw = 16'h1231; cyc(3);
        v0 = n_valid; e0 = n_error;
        press(20, 15);
        check("dup_errors", 16'(n_error - e0), 16'd1);
        check("dup_novalid", 16'(n_valid - v0), 16'd0);
        check("dup_code", 16'(last_code), 16'd2);
        check("dup_guess_kept", guess, 16'h1234);

        // Non-decimal plus duplicate: decimal cause wins
        sw = 16'hA1A2; cyc(3);
        e0 = n_error;
        press(20, 15);
        check("dec_errors", 16'(n_error - e0), 16'd1);
        check("dec_code", 16'(last_code), 16'd1);

        // Bounce then stable, then a short glitch
        sw = 16'h4321; cyc(3);
        v0 = n_valid; r0 = n_rise;
        for (int i = 0; i < 15; i++) begin
            confirm = ~confirm;
            cyc(2);
        end
        press(20, 15);
        check("bounce_rises", 16'(n_rise - r0), 16'd1);
        check("bounce_pulses", 16'(n_valid - v0), 16'd1);
        r0 = n_rise;
        press(3, 15);
        check("glitch_rises", 16'(n_rise - r0), 16'd0);
        check("glitch_pulses", 16'(n_valid - v0), 16'd1);

        // Press ignored while accept is low; later press snapshots before switch change
        accept = 1'b0; sw = 16'h5678; cyc(3);
        v0 = n_valid; e0 = n_error;
        press(20, 15);
        check("noaccept_pulses", 16'(n_valid - v0 + n_error - e0), 16'd0);
        accept = 1'b1;
        confirm = 1'b1;
        budget = 0;
        while (!(m_level && !m_prev) && budget < 50) begin
            cyc(1);
            budget++;
        end
        check("press_wait", 16'(budget < 50), 16'd1);
        cyc(2);
        sw = 16'h9012;
        cyc(95);
        confirm = 1'b0;
        cyc(15);
        check("hold_valid", 16'(n_valid - v0), 16'd1);
        check("hold_noerr", 16'(n_error - e0), 16'd0);
        check("hold_guess", guess, 16'h5678);

        // Reset during CAPTURE abandons the check
        sw = 16'h2468; cyc(3);
        v0 = n_valid; e0 = n_error;
        confirm = 1'b1;
        budget = 0;
        while (m_delay != 2 && budget < 50) begin
            cyc(1);
            budget++;
        end
        check("capture_wait", 16'(budget < 50), 16'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_guess", guess, 16'h0);
        check("midrst_valid", 16'(guess_valid), 16'd0);
        check("midrst_error", 16'(guess_error), 16'd0);
        check("midrst_code", 16'(err_code), 16'd0);
        check("midrst_busy", 16'(busy), 16'd0);
        check("midrst_btn", 16'(btn_level), 16'd0);
        confirm = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(20);
        check("midrst_nopulse", 16'(n_valid - v0 + n_error - e0), 16'd0);
        sw = 16'h1357; cyc(3);
        press(20, 15);
        check("after_rst_valid", 16'(n_valid - v0), 16'd1);
        check("after_rst_guess", guess, 16'h1357);

        // Button held through reset release counts as a press
        v0 = n_valid;
        confirm = 1'b1;
        #2 reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        press(15, 15);
        check("held_rst_valid", 16'(n_valid - v0), 16'd1);

        // Random presses, bounce, accept and switch changes
        for (int it = 0; it < 30; it++) begin
            sw = ($urandom_range(0, 1) == 1) ? rand_distinct() : 16'($urandom);
            accept = ($urandom_range(0, 3) != 0);
            cyc(3);
            nb = int'($urandom_range(0, 8));
            for (int b = 0; b < nb; b++) begin
                confirm = 1'($urandom_range(0, 1));
                cyc(1);
            end
            confirm = 1'b1;
            hold = int'($urandom_range(3, 30));
            for (int h = 0; h < hold; h++) begin
                if ($urandom_range(0, 7) == 0) sw = 16'($urandom);
                if ($urandom_range(0, 9) == 0) accept = ~accept;
                cyc(1);
            end
            confirm = 1'b0;
            cyc(int'($urandom_range(3, 20)));
        end
        confirm = 1'b0;
        cyc(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/guess_input_ctrl.md
Name: guess_input_ctrl

Overview:
- Input-side front end for the Bulls & Cows board: the player-to-game direction, mirroring the display path that drives an/seg.
- Synchronises and debounces the confirm button and synchronises the 16 switches.
- On a qualified press, snapshots the switches as four BCD digits and validates them (decimal, all distinct).
- Presents the game FSM with either a one-cycle guess_valid (plus stable guess) or a one-cycle guess_error (plus cause); sits between top-level pins and the game core.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to change the debounced button level (10 ms at 100 MHz); minimum 2.
- SYNC_STAGES, 2, flip-flop stages in the synchronisers for confirm and SW; minimum 2.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- sw  input  16  raw switches; digit3 = sw[15:12] … digit0 = sw[3:0].
- confirm  input  1  raw push button, active high, bouncy.
- accept  input  1  game FSM ready to take a guess; presses seen while low are ignored.
- guess  output  16  last accepted guess.
- guess_valid  output  1  one-cycle pulse; guess updated in the same cycle.
- guess_error  output  1  one-cycle pulse; the snapshot was rejected.
- err_code  output  2  0 none, 1 non-decimal digit (>9), 2 repeated digit; valid while guess_error is high, otherwise 0.
- busy  output  1  high from capture until the button is released.
- btn_level  output  1  debounced button level.

Behaviour:
- Reset (async assert, sync release from the clock's view):
  - guess = 0, guess_valid = 0, guess_error = 0, err_code = 0, busy = 0, btn_level = 0.
  - Synchroniser flops = 0, debounce counter = 0, FSM = WAIT_PRESS.
  - Reset mid-operation abandons any pending check; no pulse is emitted.
- Synchronisers:
  - confirm and sw each pass through SYNC_STAGES flops.
  - The snapshot uses the synchronised sw; there is no per-bit debounce on the switches.
- Debounce:
  - The counter clears whenever synchronised confirm equals btn_level.
  - Otherwise it increments; on reaching DEBOUNCE_CYCLES-1, btn_level toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never toggles btn_level.
- press_evt = btn_level rising edge (registered previous level), one cycle.
- Button held through reset release: btn_level rises after debounce, and this counts as a press.
- FSM (registered), states WAIT_PRESS, CAPTURE, CHECK, WAIT_RELEASE:
  - WAIT_PRESS: if press_evt and accept, then snap <= synced sw, go to CAPTURE. If press_evt with accept low, stay (the press is dropped; no later replay).
  - CAPTURE: register dec_err = any nibble > 9 and dup_err = any pair of nibbles equal (6 comparisons); go to CHECK.
  - CHECK: if dec_err, then guess_error <= 1, err_code <= 1 (decimal check has priority). Else if dup_err, then guess_error <= 1, err_code <= 2. Else guess <= snap, guess_valid <= 1. Go to WAIT_RELEASE.
  - WAIT_RELEASE: pulses return to 0 (err_code to 0) after one cycle. Stay until btn_level = 0, then go to WAIT_PRESS.
- busy = 1 in CAPTURE, CHECK and WAIT_RELEASE.
- Latency: press_evt in cycle T gives guess_valid or guess_error high in cycle T+3, for exactly one cycle.
- guess_valid and guess_error are never high together.
- guess changes only on guess_valid; rejected guesses leave it untouched.
- A switch change after cycle T does not affect the result.
- accept is sampled only in WAIT_PRESS. Dropping accept after capture does not cancel the result.
- One press yields at most one pulse; holding the button yields nothing more until release plus a new debounced press.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Valid guess:
  - Stimulus: sw=16'h1234, accept=1; confirm held high 20 cycles, then low.
  - Response: exactly one guess_valid, guess=16'h1234, err_code=0; pulse 3 cycles after btn_level rises; busy low after release debounce.
- Repeated digit:
  - Stimulus: sw=16'h1231, press.
  - Response: one guess_error, err_code=2, guess keeps its prior value 16'h1234.
- Non-decimal with a duplicate:
  - Stimulus: sw=16'hA1A2, press.
  - Response: guess_error, err_code=1 (priority over duplicate).
- Bounce:
  - Stimulus: confirm toggles every 2 cycles for 30 cycles, then stable high.
  - Response: btn_level rises once, exactly one pulse; a 3-cycle high glitch yields no btn_level change.
- accept and hold:
  - Stimulus: press with accept=0, release, then press again with accept=1 and hold 100 cycles; switch sw from 16'h5678 to 16'h9012 two cycles after press_evt.
  - Response: first press produces no pulse. Second press produces one guess_valid with guess=16'h5678 and no further pulse during the hold.
- Reset mid-check:
  - Stimulus: assert reset in the CAPTURE cycle.
  - Response: all outputs 0 immediately, no pulse after release; a following normal press works.
